// File: rtl/md_unit.sv
// md_unit -- execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
//
// Multiply finishes in one cycle after the start cycle. Divide is a radix-2
// restoring divider on operand magnitudes: WIDTH iterations, then a sign fix.
// While an operation is in flight md_stallE holds the pipeline. The result
// is written to hi_outE/lo_outE and held until the next completion.
//
// Optional build macro: MD_DIV_EARLY_EN
//   When defined, a divide whose divisor is zero or whose |dividend| is less
//   than |divisor| finishes after a single DIV cycle. Its result is the same
//   as the full iterative run would give.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   startE     in   md instruction present in E (held high while stalled)
//   mulOrdivE  in   0 = multiply, 1 = divide
//   mdIsSignE  in   1 = signed, 0 = unsigned
//   srcaE      in   multiplicand / dividend
//   srcbE      in   multiplier / divisor
//   cancelE    in   E-stage flush; aborts any operation
//   md_stallE  out  stall request to the hazard unit
//   md_validE  out  one-cycle pulse, result valid on hi_outE/lo_outE
//   hi_outE    out  product high word / remainder
//   lo_outE    out  product low word / quotient
module md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             mulOrdivE,
    input  logic             mdIsSignE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             cancelE,
    output logic             md_stallE,
    output logic             md_validE,
    output logic [WIDTH-1:0] hi_outE,
    output logic [WIDTH-1:0] lo_outE
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   aReg;     // multiplicand, or dividend bits / quotient
    logic [WIDTH-1:0]   bReg;     // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   remReg;   // partial remainder
    logic               isSign;
    logic               negQ;     // quotient negated at the end
    logic               negR;     // remainder negated at the end

    logic start;
    assign start = startE & ~cancelE;

    // Magnitudes use one extra bit so that the most negative operand
    // converts without truncation.
    logic [WIDTH:0] aExt, bExt, aMag, bMag;
    assign aExt = {mdIsSignE & srcaE[WIDTH-1], srcaE};
    assign bExt = {mdIsSignE & srcbE[WIDTH-1], srcbE};
    assign aMag = aExt[WIDTH] ? -aExt : aExt;
    assign bMag = bExt[WIDTH] ? -bExt : bExt;

    // Full-width product: both operands sign- or zero-extended to 2*WIDTH+2.
    logic signed [2*WIDTH+1:0] mulA, mulB, prod;
    assign mulA = {{(WIDTH+2){isSign & aReg[WIDTH-1]}}, aReg};
    assign mulB = {{(WIDTH+2){isSign & bReg[WIDTH-1]}}, bReg};
    assign prod = mulA * mulB;

    // One restoring step. The dividend bits shift out of the top of aReg
    // while quotient bits shift in at the bottom.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             qBit;
    logic [WIDTH-1:0] remStep, quoStep;
    assign shifted = {remReg, aReg[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, bReg};
    assign qBit    = ~diff[WIDTH+1];
    assign remStep = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quoStep = {aReg[WIDTH-2:0], qBit};

    logic             early;
    logic [WIDTH-1:0] earlyQ, earlyR;
`ifdef MD_DIV_EARLY_EN
    // Only valid on the first DIV cycle, while aReg still holds |dividend|.
    logic earlyZero, earlySmall;
    assign earlyZero  = (cnt == '0) && (bReg == '0);
    assign earlySmall = (cnt == '0) && (aReg < bReg);
    assign early      = earlyZero | earlySmall;
    assign earlyQ     = earlyZero ? '1 : '0;
    assign earlyR     = aReg;
`else
    assign early  = 1'b0;
    assign earlyQ = '0;
    assign earlyR = '0;
`endif

    logic             lastIter, divFinish;
    logic [WIDTH-1:0] finQ, finR, sgnQ, sgnR;
    assign lastIter  = (cnt == CNT_W'(WIDTH-1));
    assign divFinish = lastIter | early;
    assign finQ      = early ? earlyQ : quoStep;
    assign finR      = early ? earlyR : remStep;
    assign sgnQ      = negQ ? -finQ : finQ;
    assign sgnR      = negR ? -finR : finR;

    logic unused;
    assign unused = ^{aMag[WIDTH], bMag[WIDTH], prod[2*WIDTH+1:2*WIDTH], diff[WIDTH]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = mulOrdivE ? DIV : MUL;
            MUL:  stateNext = DONE;
            DIV:  if (divFinish) stateNext = DONE;
            DONE: stateNext = IDLE;   // startE still high here must not restart
            default: stateNext = IDLE;
        endcase
        if (cancelE) stateNext = IDLE;
    end

    // Output logic. The stall is combinational in IDLE so the hazard unit
    // sees it in the start cycle itself.
    always_comb begin
        md_stallE = 1'b0;
        md_validE = 1'b0;
        case (state)
            IDLE:    md_stallE = rst & start;
            MUL,
            DIV:     md_stallE = ~cancelE;
            DONE:    md_validE = ~cancelE;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            aReg    <= '0;
            bReg    <= '0;
            remReg  <= '0;
            isSign  <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            hi_outE <= '0;
            lo_outE <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    isSign <= mdIsSignE;
                    cnt    <= '0;
                    remReg <= '0;
                    if (mulOrdivE) begin
                        aReg <= aMag[WIDTH-1:0];
                        bReg <= bMag[WIDTH-1:0];
                        negQ <= aExt[WIDTH] ^ bExt[WIDTH];
                        negR <= aExt[WIDTH];
                    end else begin
                        aReg <= srcaE;
                        bReg <= srcbE;
                    end
                end
                MUL: if (!cancelE) begin
                    {hi_outE, lo_outE} <= prod[2*WIDTH-1:0];
                end
                DIV: if (!cancelE) begin
                    aReg   <= quoStep;
                    remReg <= remStep;
                    cnt    <= cnt + 1'b1;
                    if (divFinish) begin
                        hi_outE <= sgnR;
                        lo_outE <= sgnQ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Fed by the controller's execute-stage flags (mulOrdivE, mdIsSignE, mdToHiloE) and the forwarded operands.
- Produces the 64-bit {hi,lo} result that the mem-stage HI/LO write path consumes.
- Raises a stall request while an operation is in flight; multiply has fixed short latency, divide is iterative radix-2.

Parameters:
- WIDTH, 32, operand width; hi/lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- startE  in  1  md instruction present in E (mdToHiloE qualified by valid); held high while pipeline stalled
- mulOrdivE  in  1  0 = multiply, 1 = divide
- mdIsSignE  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu)
- srcaE  in  WIDTH  rs operand (multiplicand / dividend)
- srcbE  in  WIDTH  rt operand (multiplier / divisor)
- cancelE  in  1  flush of E stage (exception/branch); aborts operation
- md_stallE  out  1  stall request to hazard unit
- md_validE  out  1  one-cycle pulse, result valid on hi_outE/lo_outE
- hi_outE  out  WIDTH  product high word / remainder
- lo_outE  out  WIDTH  product low word / quotient

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, hi_outE=0, lo_outE=0, md_validE=0, md_stallE=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - startE=1 & cancelE=0: latch operands and sign flags; go MUL if mulOrdivE=0, else DIV.
  - md_stallE is combinational in IDLE: 1 if startE & ~cancelE, so the stall appears in the start cycle.
- MUL: registered product (signed or unsigned, full 2*WIDTH) loaded into {hi,lo}; md_stallE=1; -> DONE.
- DIV:
  - Restoring divide on magnitudes (|a|,|b| when signed), one quotient bit per cycle, WIDTH cycles, counter 0..WIDTH-1; md_stallE=1.
  - On the final iteration apply sign fix: quotient negated if sa^sb; remainder negated if sa. -> DONE.
- DONE:
  - md_stallE=0, md_validE=1, outputs hold the result.
  - Pipeline advances this cycle; -> IDLE unconditionally. startE still high in DONE must not restart.
- Outputs hold the last result in IDLE until the next completion.
- Latency from start cycle: mul = 2 stall cycles, valid in cycle 2; div = WIDTH+1 stall cycles, valid in cycle WIDTH+1 (33 for WIDTH=32).
- Divide by zero: quotient = all-ones magnitude, remainder = dividend magnitude, then the normal sign fix. Deterministic; no exception.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- Magnitude of 0x80000000 uses WIDTH+1-bit internal arithmetic; no truncation.
- cancelE=1 in any state:
  - -> IDLE next cycle; md_validE=0; hi/lo outputs unchanged; md_stallE=0 that same cycle.
  - cancelE together with startE in IDLE: no operation started.
- Reset mid-operation: immediate return to reset values; no partial result visible.

Optional Feature:
- Macro MD_DIV_EARLY_EN.
- Defined:
  - In DIV, if the latched divisor is 0, or |dividend| < |divisor|, skip iterations and go to DONE after one DIV cycle.
  - Results are identical to the full algorithm: div-by-zero values as above; the second case gives quotient 0, remainder = dividend.
  - Divide latency for these cases = 2 stall cycles.
- Undefined: every divide takes the full WIDTH+1 stall cycles.

Test Plan:
- Unsigned multiply: multu 0xFFFFFFFF x 0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; md_stallE high exactly 2 cycles; md_validE one pulse.
- Signed multiply: mult -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed divide: div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; stall 33 cycles. Unsigned divide: divu 100 / 7 -> lo=14, hi=2.
- Edge divides:
  - 0x80000000 / -1 signed -> lo=0x80000000, hi=0.
  - divu 5 / 0 -> lo=0xFFFFFFFF, hi=5; with MD_DIV_EARLY_EN, stall 2 cycles instead of 33.
- Cancel at DIV iteration 10 -> md_stallE=0 in that cycle, IDLE next cycle, no md_validE, hi/lo keep the previous result.
- Next-op behaviour: back-to-back md ops, startE high in DONE -> no restart; a new startE after IDLE runs correctly.
- Reset: rst asserted mid-divide -> all outputs 0 asynchronously.
